decoder_3x8_buf: RTL and testbench



---
 rtl/decoder_3x8_buf.sv | 114 +++++++++++
 tb/tb_decoder_3x8_buf.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/decoder_3x8_buf.sv
// decoder_3x8_buf
// Regenerates an 8-bit one-hot line vector from a 3-bit code.
// Codes pass through a 2-entry valid/ready buffer, so the producer and the
// consumer can stall independently.
// A saturating counter records how many codes have been delivered.
//
// Outputs are decoded from registered state only:
// - There is no same-cycle bypass.
// - in_ready has no combinational path from out_ready.

module decoder_3x8_buf #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       in_code,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             flush,
    output logic [7:0]       out_onehot,
    output logic [2:0]       out_code,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] dec_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Buffer storage and bookkeeping.
    logic [2:0]       mem_q [2];
    logic             rd_ptr_q, rd_ptr_d;
    logic             wr_ptr_q, wr_ptr_d;
    logic [1:0]       occ_q, occ_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             push;
    logic             pop;
    logic [2:0]       head_code;

    // Handshake terms. Both are functions of the registered occupancy only.
    assign in_ready  = (occ_q != 2'd2);
    assign out_valid = (occ_q != 2'd0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    assign head_code = mem_q[rd_ptr_q];

    // The head entry is only visible while valid; otherwise the output is all zeros.
    assign out_code  = out_valid ? head_code : 3'b000;
    assign dec_count = cnt_q;

    // One comparator per output line.
    // This gives exactly one hot bit whenever out_valid is high.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_onehot
            assign out_onehot[gi] = out_valid && (head_code == 3'(gi));
        end
    endgenerate

    // Next-state logic for pointers, occupancy and the delivered-code counter.
    // Flush wins over any handshake in the same cycle:
    // - A pop in that cycle is neither delivered nor counted.
    // - A push in that cycle is discarded.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        occ_d    = occ_q;
        cnt_d    = cnt_q;
        if (flush) begin
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
            occ_d    = 2'd0;
        end else begin
            if (push) begin
                wr_ptr_d = ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_d = ~rd_ptr_q;
                if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            case ({push, pop})
                2'b10:   occ_d = occ_q + 2'd1;
                2'b01:   occ_d = occ_q - 2'd1;
                default: occ_d = occ_q;
            endcase
        end
    end

    // Control state: cleared asynchronously so outputs drop at once on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            occ_q    <= 2'd0;
            cnt_q    <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            occ_q    <= occ_d;
            cnt_q    <= cnt_d;
        end
    end

    // Code storage.
    // No reset is needed here because stale entries are masked by out_valid.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem_q[wr_ptr_q] <= in_code;
        end
    end

endmodule

// File: tb/tb_decoder_3x8_buf.sv
// tb_decoder_3x8_buf
// Scoreboard bench for decoder_3x8_buf.
// Expected codes are queued when the bench hands a code to the buffer.
// They are popped and compared when the consumer takes the head entry.
//
// A second instance with CNT_W=2 shares all inputs.
// Its counter must read min(delivered, 3).

module tb_decoder_3x8_buf;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] in_code;
    logic       in_valid;
    logic       flush;
    logic       out_ready;

    logic       in_ready, out_valid;
    logic [7:0] out_onehot;
    logic [2:0] out_code;
    logic [7:0] dec_count;

    logic       in_ready_s, out_valid_s;
    logic [7:0] out_onehot_s;
    logic [2:0] out_code_s;
    logic [1:0] dec_count_s;

    int         checks = 0;
    int         errors = 0;
    logic [2:0] exp_q[$];
    int         exp_cnt = 0;

    always #5 clk = ~clk;

    decoder_3x8_buf #(.CNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_code   (in_code),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .flush     (flush),
        .out_onehot(out_onehot),
        .out_code  (out_code),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dec_count (dec_count)
    );

    decoder_3x8_buf #(.CNT_W(2)) dut_sat (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_code   (in_code),
        .in_valid  (in_valid),
        .in_ready  (in_ready_s),
        .flush     (flush),
        .out_onehot(out_onehot_s),
        .out_code  (out_code_s),
        .out_valid (out_valid_s),
        .out_ready (out_ready),
        .dec_count (dec_count_s)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Compare every output against the scoreboard state.
    task automatic check_outputs();
        int         n;
        logic [2:0] head;
        n    = exp_q.size();
        head = (n != 0) ? exp_q[0] : 3'd0;
        chk("in_ready",   32'(in_ready),  32'(n != 2));
        chk("out_valid",  32'(out_valid), 32'(n != 0));
        chk("out_code",   32'(out_code),  (n != 0) ? 32'(head) : 32'd0);
        chk("out_onehot", 32'(out_onehot), (n != 0) ? (32'd1 << head) : 32'd0);
        chk("dec_count",  32'(dec_count), (exp_cnt > 255) ? 32'd255 : 32'(exp_cnt));
        chk("dec_count_sat", 32'(dec_count_s), (exp_cnt > 3) ? 32'd3 : 32'(exp_cnt));
        chk("sat_onehot", 32'(out_onehot_s), (n != 0) ? (32'd1 << head) : 32'd0);
    endtask

    // One clock cycle:
    // - Drive inputs after the falling edge, then check state outputs.
    // - Update the model with what the coming rising edge will do.
    task automatic cycle(input logic iv, input logic [2:0] code, input logic ordy, input logic fl);
        logic push, pop;
        @(negedge clk);
        in_valid  = iv;
        in_code   = code;
        out_ready = ordy;
        flush     = fl;
        #1;
        check_outputs();
        push = iv && (exp_q.size() != 2);
        pop  = ordy && (exp_q.size() != 0);
        if (fl) begin
            $display("flush: %0d entries discarded, count %0d", exp_q.size(), exp_cnt);
            exp_q.delete();
        end else begin
            if (pop) begin
                $display("deliver code %0d onehot %02h count %0d", exp_q[0], out_onehot, exp_cnt + 1);
                void'(exp_q.pop_front());
                exp_cnt++;
            end
            if (push) begin
                exp_q.push_back(code);
            end
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_code   = 3'd0;
        flush     = 1'b0;
        out_ready = 1'b0;

        #1;
        check_outputs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Idle after reset.
        repeat (3) cycle(1'b0, 3'd0, 1'b1, 1'b0);

        // Codes 0..7 back to back, consumer always ready.
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 3'(i), 1'b1, 1'b0);
        end
        repeat (2) cycle(1'b0, 3'd0, 1'b1, 1'b0);
        chk("count_after_8", 32'(dec_count), 32'd8);

        // Stalled consumer: 5 and 2 fill the buffer and 7 waits.
        cycle(1'b1, 3'd5, 1'b0, 1'b0);
        cycle(1'b1, 3'd2, 1'b0, 1'b0);
        cycle(1'b1, 3'd7, 1'b0, 1'b0);
        cycle(1'b1, 3'd7, 1'b0, 1'b0);
        cycle(1'b1, 3'd7, 1'b1, 1'b0);
        cycle(1'b1, 3'd7, 1'b1, 1'b0);
        repeat (2) cycle(1'b0, 3'd0, 1'b1, 1'b0);

        // One entry held, then a simultaneous push and pop.
        cycle(1'b1, 3'd3, 1'b0, 1'b0);
        cycle(1'b1, 3'd6, 1'b1, 1'b0);
        cycle(1'b0, 3'd0, 1'b0, 1'b0);
        cycle(1'b0, 3'd0, 1'b1, 1'b0);
        cycle(1'b0, 3'd0, 1'b1, 1'b0);

        // Full buffer flushed while both handshakes are offered.
        cycle(1'b1, 3'd1, 1'b0, 1'b0);
        cycle(1'b1, 3'd4, 1'b0, 1'b0);
        cycle(1'b1, 3'd5, 1'b1, 1'b1);
        cycle(1'b0, 3'd0, 1'b0, 1'b0);
        cycle(1'b1, 3'd6, 1'b1, 1'b0);
        repeat (2) cycle(1'b0, 3'd0, 1'b1, 1'b0);

        // Random traffic with occasional flushes.
        for (int i = 0; i < 300; i++) begin
            cycle(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                  1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 24) == 0));
        end

        // Reset while codes are buffered: outputs drop before the next edge.
        cycle(1'b1, 3'd2, 1'b0, 1'b0);
        cycle(1'b1, 3'd7, 1'b0, 1'b0);
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        flush     = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        exp_cnt = 0;
        check_outputs();
        cycle(1'b0, 3'd0, 1'b1, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) cycle(1'b0, 3'd0, 1'b1, 1'b0);
        cycle(1'b1, 3'd4, 1'b1, 1'b0);
        repeat (2) cycle(1'b0, 3'd0, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
